// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and a small
// elaboration-time helper used to size the latency counter.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    localparam int MDU_OP_W = 3;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu.sv
// MIPS-style HI/LO multiply/divide unit. Arithmetic is combinational at accept;
// a down-counter models the multi-cycle latency before HI/LO are committed.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cancel,
    output logic                busy,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int MAX_LAT = max_int(MULT_LAT, DIV_LAT);
    // A single-cycle latency still needs a 1-bit counter to exist.
    localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    logic               busy_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   shadow_hi_reg;
    logic [WIDTH-1:0]   shadow_lo_reg;

    logic               accept;
    logic               long_op;
    logic [CNT_W-1:0]   cnt_load;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic               mul_signed;
    logic               div_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign accept = start & ~busy_reg & ~cancel;

    // Multiply: extend to 2*WIDTH so one unsigned multiplier serves both forms.
    always_comb begin
        mul_signed = (op == MDU_MULT);
        a_ext      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod       = a_ext * b_ext;
    end

    // Divide on magnitudes, then restore signs. The overflow case
    // (-2^(W-1) / -1) falls out naturally as quotient -2^(W-1), remainder 0.
    always_comb begin
        div_signed = (op == MDU_DIV);
        a_neg      = div_signed & a[WIDTH-1];
        b_neg      = div_signed & b[WIDTH-1];
        a_mag      = a_neg ? (~a + 1'b1) : a;
        b_mag      = b_neg ? (~b + 1'b1) : b;
        q_mag      = (b_mag != '0) ? (a_mag / b_mag) : '0;
        r_mag      = (b_mag != '0) ? (a_mag % b_mag) : '0;
        quo        = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem        = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    always_comb begin
        long_op  = 1'b0;
        cnt_load = '0;
        res_hi   = prod[2*WIDTH-1:WIDTH];
        res_lo   = prod[WIDTH-1:0];
        case (op)
            MDU_MULT, MDU_MULTU: begin
                long_op  = 1'b1;
                cnt_load = MULT_LOAD;
            end
            MDU_DIV, MDU_DIVU: begin
                long_op  = 1'b1;
                cnt_load = DIV_LOAD;
                if (b == '0) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg      <= 1'b0;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            shadow_hi_reg <= '0;
            shadow_lo_reg <= '0;
        end else if (cancel) begin
            // Cancel beats completion and any same-cycle start.
            busy_reg      <= 1'b0;
            cnt_reg       <= '0;
            shadow_hi_reg <= '0;
            shadow_lo_reg <= '0;
        end else if (busy_reg) begin
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
                hi_reg   <= shadow_hi_reg;
                lo_reg   <= shadow_lo_reg;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end else if (accept) begin
            if (long_op) begin
                busy_reg      <= 1'b1;
                cnt_reg       <= cnt_load;
                shadow_hi_reg <= res_hi;
                shadow_lo_reg <= res_lo;
            end else if (op == MDU_MTHI) begin
                hi_reg <= a;
            end else if (op == MDU_MTLO) begin
                lo_reg <= a;
            end
        end
    end

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a reference model pushes expected HI/LO and busy
// length per transaction; results are popped when the unit goes idle.
module tb_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [2:0]   op     = '0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mdu #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model built on 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ohi, input logic [W-1:0] olo,
                         output logic [W-1:0] mh, output logic [W-1:0] ml, output int lat);
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        mh = ohi; ml = olo; lat = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); mh = p[63:32]; ml = p[31:0]; lat = 5; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; mh = p[63:32]; ml = p[31:0]; lat = 5; end
            3'd2: begin
                lat = 10;
                if (y == 0) begin mh = x; ml = '1; end
                else begin
                    sq = sx / sy; sr = sx % sy;
                    p = 64'(sq); ml = p[31:0];
                    p = 64'(sr); mh = p[31:0];
                end
            end
            3'd3: begin
                lat = 10;
                if (y == 0) begin mh = x; ml = '1; end
                else begin ml = x / y; mh = x % y; end
            end
            3'd4: mh = x;
            3'd5: ml = x;
            default: ;
        endcase
    endtask

    // Issue one op; optionally cancel, or poke a stray MTLO start, on a given busy cycle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag, input int cancel_at, input int restart_at);
        exp_t         e;
        logic [W-1:0] ph, pl;
        int           n;
        ph = hi; pl = lo;
        model(o, x, y, ph, pl, e.hi, e.lo, e.lat);
        if (cancel_at > 0) begin
            e.hi = ph; e.lo = pl; e.lat = cancel_at;
        end
        sb_q.push_back(e);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            start = 1'b0; cancel = 1'b0;
            check_val({tag, "_hold_hi"}, hi, ph);
            check_val({tag, "_hold_lo"}, lo, pl);
            if (n + 1 == cancel_at) cancel = 1'b1;
            if (n + 1 == restart_at) begin
                op = MDU_MTLO; a = 32'hDEAD_BEEF; start = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; cancel = 1'b0;
        e = sb_q.pop_front();
        check_val({tag, "_busy_cycles"}, W'(n), W'(e.lat));
        check_val({tag, "_hi"}, hi, e.hi);
        check_val({tag, "_lo"}, lo, e.lo);
        $display("txn %-18s op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h",
                 tag, o, x, y, n, hi, lo);
    endtask

    initial begin
        logic [W-1:0] ph, pl;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_busy", W'(busy), '0);
        check_val("reset_hi", hi, '0);
        check_val("reset_lo", lo, '0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, "mult_signed", 0, 0);
        check_val("mult_signed_hi_const", hi, 32'hFFFF_FFFF);
        check_val("mult_signed_lo_const", lo, 32'hFFFF_FFFA);

        run_op(MDU_DIVU, 32'd100, 32'd7, "divu", 0, 0);
        check_val("divu_lo_const", lo, 32'd14);
        check_val("divu_hi_const", hi, 32'd2);

        run_op(MDU_DIV, 32'h8000_0000, 32'd0, "div_by_zero", 0, 0);
        check_val("dbz_lo_const", lo, 32'hFFFF_FFFF);
        check_val("dbz_hi_const", hi, 32'h8000_0000);

        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 0, 0);
        check_val("ovf_lo_const", lo, 32'h8000_0000);
        check_val("ovf_hi_const", hi, 32'd0);

        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 0, 0);

        run_op(MDU_MTLO, 32'h0000_1234, 32'd0, "mtlo", 0, 0);
        check_val("mtlo_lo_const", lo, 32'h0000_1234);
        check_val("mtlo_busy", W'(busy), '0);
        run_op(MDU_MTHI, 32'h0000_CAFE, 32'd0, "mthi", 0, 0);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_cancel", 3, 0);
        run_op(MDU_MULT, 32'd7, 32'd9, "cancel_last", 5, 0);
        run_op(MDU_MULT, 32'd2, 32'd3, "busy_start", 0, 2);

        // Cancel and start together: neither a move nor a long op may land.
        ph = hi; pl = lo;
        @(negedge clk);
        op = MDU_MTHI; a = 32'h5555_5555; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        op = MDU_MULT; a = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check_val("cancel_start_busy", W'(busy), '0);
        check_val("cancel_start_hi", hi, ph);
        check_val("cancel_start_lo", lo, pl);
        $display("txn %-18s hi=%h lo=%h busy=%0d", "cancel_and_start", hi, lo, busy);

        run_op(3'd6, 32'h1111_1111, 32'h2222_2222, "undef_op", 0, 0);

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(rop, ra, rb, $sformatf("rand_%0d", i), 0, 0);
        end

        run_op(MDU_MTHI, 32'hAAAA_0001, 32'd0, "mthi_pre_reset", 0, 0);
        @(negedge clk);
        op = MDU_DIV; a = 32'd50; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("midreset_busy", W'(busy), '0);
        check_val("midreset_hi", hi, '0);
        check_val("midreset_lo", lo, '0);
        $display("txn %-18s hi=%h lo=%h busy=%0d", "reset_mid_div", hi, lo, busy);
        @(posedge clk); #2 reset = 1'b1;

        run_op(MDU_MULT, 32'd2, 32'd3, "post_reset", 0, 0);
        check_val("post_reset_lo_const", lo, 32'd6);
        check_val("post_reset_hi_const", hi, 32'd0);

        check_val("scoreboard_empty", W'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
